// File: rtl/lut_neuron_pkg.sv
// -----------------------------------------------------------------------------
// lut_neuron_pkg
//   Shared types and constants for the runtime-loadable LUT neuron array.
//   - state_e   : controller states (LOAD while tables are written, RUN while
//                 streaming inferences)
//   - cfg_w()   : width of the cfg_neuron index, never less than one bit
//   - DEF_*     : default parameter values for the array
// -----------------------------------------------------------------------------
package lut_neuron_pkg;

  localparam int DEF_NEURONS  = 4;
  localparam int DEF_IN_BITS  = 8;
  localparam int DEF_OUT_BITS = 1;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A single-neuron array still needs a one-bit index port.
  function automatic int cfg_w(input int neurons);
    return (neurons > 1) ? $clog2(neurons) : 1;
  endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// -----------------------------------------------------------------------------
// lut_neuron_ram
//   One neuron truth table: 2**ADDR_W entries of DATA_W bits, mapped to
//   distributed RAM. Synchronous write, asynchronous lookup read.
//   Optional macro LUT_READBACK_EN adds a second asynchronous read port used
//   for configuration readback.
//
//   clk            : clock, write on rising edge
//   we/waddr/wdata : write port
//   raddr/rdata    : lookup read port (combinational)
//   rb_addr/rb_data: readback read port (combinational, LUT_READBACK_EN only)
// -----------------------------------------------------------------------------
module lut_neuron_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
`ifdef LUT_READBACK_EN
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
`endif
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the table has no reset on purpose; contents must survive rst so a
  // reset mid-stream can resume inference without reloading, and a reset
  // would also stop the array mapping onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

`ifdef LUT_READBACK_EN
  assign rb_data = mem[rb_addr];
`endif

endmodule

// File: rtl/lut_neuron_array.sv
// -----------------------------------------------------------------------------
// lut_neuron_array
//   NEURONS truth-table neurons evaluated in parallel. Tables are loaded in
//   LOAD state through the cfg_* port, then cfg_done moves to RUN where inputs
//   stream through a single output register under valid/ready handshakes
//   (one cycle latency, one result per cycle). Only rst returns to LOAD.
//   Optional macro LUT_READBACK_EN adds cfg_re/cfg_rdata table readback.
//
//   clk, rst                 : clock, synchronous active-high reset
//   cfg_we/neuron/addr/data  : table write port (LOAD only)
//   cfg_done                 : ends loading
//   cfg_err                  : sticky error (bad index or write in RUN)
//   run                      : high in RUN
//   in_data/in_valid/in_ready: input stream, neuron n address at n*IN_BITS
//   out_data/out_valid/out_ready : output stream, neuron n at n*OUT_BITS
//   cfg_re/cfg_rdata         : readback (LUT_READBACK_EN only)
// -----------------------------------------------------------------------------
module lut_neuron_array
  import lut_neuron_pkg::*;
#(
  parameter int NEURONS  = DEF_NEURONS,
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [cfg_w(NEURONS)-1:0]    cfg_neuron,
  input  logic [IN_BITS-1:0]           cfg_addr,
  input  logic [OUT_BITS-1:0]          cfg_data,
  input  logic                         cfg_done,
  output logic                         cfg_err,
  output logic                         run,
`ifdef LUT_READBACK_EN
  input  logic                         cfg_re,
  output logic [OUT_BITS-1:0]          cfg_rdata,
`endif
  input  logic [NEURONS*IN_BITS-1:0]   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [NEURONS*OUT_BITS-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready
);

  state_e state_q, state_d;

  logic                        cfg_err_q, cfg_err_d;
  logic                        out_valid_q, out_valid_d;
  logic [NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
  logic [NEURONS*OUT_BITS-1:0] lookup_flat;
  logic [OUT_BITS-1:0]         lookup [NEURONS];
  logic [NEURONS-1:0]          ram_we;
  logic [31:0]                 cfg_idx;
  logic                        cfg_in_range;
  logic                        loading;
  logic                        xfer;

  // Widen the index so the range test also works when NEURONS is not a
  // power of two (otherwise the port simply cannot address past the end).
  assign cfg_idx      = 32'(cfg_neuron);
  assign cfg_in_range = cfg_idx < 32'(NEURONS);

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every always_comb output is given a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (cfg_done) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = LOAD;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // in_ready depends only on registered state and out_ready, never in_valid.
  always_comb begin
    loading  = (state_q == LOAD);
    run      = (state_q == RUN);
    in_ready = run && (!out_valid_q || out_ready);
  end

  assign xfer = in_valid && in_ready;

  // ---------------- write decode, error flag, output register ----------------
  always_comb begin
    ram_we = '0;
    for (int n = 0; n < NEURONS; n++) begin
      ram_we[n] = loading && cfg_we && (cfg_idx == 32'(n));
    end

    cfg_err_d = cfg_err_q
              | (loading && cfg_we && !cfg_in_range)
              | (run && cfg_we);

    lookup_flat = '0;
    for (int n = 0; n < NEURONS; n++) begin
      lookup_flat[n*OUT_BITS +: OUT_BITS] = lookup[n];
    end

    // A transfer wins over a drain, so drain+transfer keeps out_valid high.
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = lookup_flat;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // ---------------- neuron tables ----------------
`ifdef LUT_READBACK_EN
  logic [OUT_BITS-1:0] rb_data [NEURONS];
`endif

  for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
    lut_neuron_ram #(
      .ADDR_W (IN_BITS),
      .DATA_W (OUT_BITS)
    ) u_ram (
      .clk     (clk),
      .we      (ram_we[n]),
      .waddr   (cfg_addr),
      .wdata   (cfg_data),
`ifdef LUT_READBACK_EN
      .rb_addr (cfg_addr),
      .rb_data (rb_data[n]),
`endif
      .raddr   (in_data[n*IN_BITS +: IN_BITS]),
      .rdata   (lookup[n])
    );
  end

  // ---------------- optional readback ----------------
`ifdef LUT_READBACK_EN
  logic [OUT_BITS-1:0] cfg_rdata_q, cfg_rdata_d;

  // The read samples the table before any same-edge write, so a read
  // coinciding with a write returns the old value.
  always_comb begin
    cfg_rdata_d = cfg_rdata_q;
    if (loading && cfg_re) begin
      cfg_rdata_d = '0;
      for (int n = 0; n < NEURONS; n++) begin
        if (cfg_idx == 32'(n)) cfg_rdata_d = rb_data[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rdata_q <= '0;
    end else begin
      cfg_rdata_q <= cfg_rdata_d;
    end
  end

  assign cfg_rdata = cfg_rdata_q;
`endif

endmodule

// File: tb/tb_lut_neuron_array.sv
// -----------------------------------------------------------------------------
// tb_lut_neuron_array
//   Loads neuron 0 with a[7]&a[6] and neurons 1..3 with parity, then streams
//   directed and random inputs. An input monitor pushes the expected result
//   of every accepted input into a scoreboard; an output monitor pops and
//   compares whenever a result is presented.
// -----------------------------------------------------------------------------
module tb_lut_neuron_array;
  import lut_neuron_pkg::*;

  localparam int N  = DEF_NEURONS;
  localparam int IB = DEF_IN_BITS;
  localparam int OB = DEF_OUT_BITS;
  localparam int CW = cfg_w(N);

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [CW-1:0]     cfg_neuron;
  logic [IB-1:0]     cfg_addr;
  logic [OB-1:0]     cfg_data;
  logic              cfg_done;
  logic              cfg_err;
  logic              run;
  logic [N*IB-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;
  logic [N*OB-1:0]   out_data;
  logic              out_valid;
  logic              out_ready;
`ifdef LUT_READBACK_EN
  logic              cfg_re;
  logic [OB-1:0]     cfg_rdata;
`endif

  lut_neuron_array #(.NEURONS(N), .IN_BITS(IB), .OUT_BITS(OB)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_neuron (cfg_neuron),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .run        (run),
`ifdef LUT_READBACK_EN
    .cfg_re     (cfg_re),
    .cfg_rdata  (cfg_rdata),
`endif
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fail    = 0;
  int xfer_cnt  = 0;
  int out_cnt   = 0;
  logic [N*OB-1:0] sb [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference tables straight from the neuron definitions.
  function automatic logic golden(input int n, input logic [7:0] a);
    if (n == 0) return a[7] & a[6];
    return ^a;
  endfunction

  function automatic logic [N*OB-1:0] model(input logic [N*IB-1:0] d);
    logic [N*OB-1:0] r;
    r = '0;
    for (int n = 0; n < N; n++) r[n*OB +: OB] = golden(n, d[n*IB +: IB]);
    return r;
  endfunction

  // Input monitor: record the expected result of each accepted input.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      sb.delete();
    end else if (in_valid && in_ready) begin
      sb.push_back(model(in_data));
      xfer_cnt++;
    end
  end

  // Output monitor: result presence must track the scoreboard, data must match.
  always @(negedge clk) begin
    if (!rst && run) begin
      check("out_valid_vs_sb", out_valid, sb.size() != 0);
      if (out_valid && sb.size() != 0) begin
        check("out_data_vs_model", out_data, sb[0]);
        if (out_ready) begin
          void'(sb.pop_front());
          out_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of streaming; fresh data only after the current word was taken.
  task automatic stream_cycle();
    logic x;
    @(negedge clk);
    x = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (x) in_data = $urandom();
  endtask

  logic [N*OB-1:0] held;
  logic [N*IB-1:0] saved;
  int base, obase;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
    cfg_done = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
`ifdef LUT_READBACK_EN
    cfg_re = 1'b0;
`endif
    repeat (2) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data, 0);
    check("rst_in_ready",  in_ready, 0);
    check("rst_run",       run, 0);
    check("rst_cfg_err",   cfg_err, 0);
    rst = 1'b0;

    // Load every entry; the (3,0xFE) write is held back to coincide with cfg_done.
    in_valid = 1'b1;
    for (int n = 0; n < N; n++) begin
      for (int a = 0; a < (1 << IB); a++) begin
        if (n == 3 && a == 8'hFE) continue;
        cfg_we = 1'b1; cfg_neuron = CW'(n); cfg_addr = IB'(a); cfg_data = golden(n, 8'(a));
        step();
        if (n == 1 && a == 0) check("load_in_ready", in_ready, 0);
      end
    end
    in_valid = 1'b0;
    cfg_neuron = CW'(3); cfg_addr = 8'hFE; cfg_data = golden(3, 8'hFE); cfg_done = 1'b1;
    step();
    cfg_we = 1'b0; cfg_done = 1'b0;
    check("done_run",      run, 1);
    check("done_in_ready", in_ready, 1);
    check("load_cfg_err",  cfg_err, 0);

    // Directed first lookup, one cycle after the transfer.
    out_ready = 1'b1;
    in_data = 32'hFF8103C0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("first_valid", out_valid, 1);
    check("first_data",  out_data, 4'b0001);
    in_data = 32'hFE000000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("write_with_done", out_data, 4'b1000);
    step();

    // Back-pressure.
    out_ready = 1'b0; in_data = $urandom(); in_valid = 1'b1;
    base = xfer_cnt;
    stream_cycle();
    for (int i = 0; i < 5; i++) begin
      held = out_data;
      check("bp_in_ready", in_ready, 0);
      stream_cycle();
      check("bp_stable", out_data, held);
    end
    check("bp_one_xfer", xfer_cnt - base, 1);
    out_ready = 1'b1;
    base = xfer_cnt;
    repeat (4) stream_cycle();
    check("bp_release_xfers", xfer_cnt - base, 4);
    in_valid = 1'b0;
    repeat (2) step();

    // Full throughput.
    base = xfer_cnt; obase = out_cnt;
    in_data = $urandom(); in_valid = 1'b1;
    repeat (256) stream_cycle();
    in_valid = 1'b0;
    step();
    check("tput_xfers",   xfer_cnt - base, 256);
    check("tput_results", out_cnt - obase, 256);

    // Random handshake mix.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      stream_cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) step();

    // Write attempt in RUN.
    cfg_we = 1'b1; cfg_neuron = '0; cfg_addr = 8'hC0; cfg_data = '0;
    step();
    cfg_we = 1'b0;
    check("run_write_err", cfg_err, 1);
    in_data = 32'h000000C0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("run_write_ignored", out_data, 4'b0001);
    step();

    // Reset with a pending result.
    out_ready = 1'b0; saved = 32'h5A3C81C0; in_data = saved; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_rst_valid", out_valid, 0);
    check("post_rst_run",   run, 0);
    check("post_rst_err",   cfg_err, 0);

`ifdef LUT_READBACK_EN
    for (int a = 0; a < (1 << IB); a++) begin
      cfg_re = 1'b1; cfg_neuron = CW'(3); cfg_addr = IB'(a);
      step();
      check("readback_n3", cfg_rdata, golden(3, 8'(a)));
    end
    cfg_re = 1'b0;
    check("readback_no_err", cfg_err, 0);
`endif

    cfg_done = 1'b1;
    step();
    cfg_done = 1'b0;
    out_ready = 1'b1; in_data = saved; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("tables_retained", out_data, model(saved));

`ifdef LUT_READBACK_EN
    held = cfg_rdata;
    cfg_re = 1'b1; cfg_neuron = '0; cfg_addr = 8'hC0;
    step();
    cfg_re = 1'b0;
    check("run_re_no_err", cfg_err, 0);
    check("run_re_ignored", cfg_rdata, held);
`endif

    repeat (2) step();
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
